// File: rtl/uart_csr_master.sv
// uart_csr_master: CSR initiator for the UART register-bus responder.
// Takes one host command at a time over valid/ready (write, read, or
// poll-until-match with bounded retries). It drives the single-cycle CSR
// write/read strobes and returns exactly one response per command.
module uart_csr_master #(
  parameter int CSR_ADDR_W = 4,
  parameter int CSR_DATA_W = 32,
  parameter int POLL_MAX   = 1024,
  parameter int POLL_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // host command channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [CSR_DATA_W-1:0] req_data,
  input  logic [CSR_DATA_W-1:0] req_mask,
  // host response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CSR_DATA_W-1:0] rsp_data,
  output logic                  rsp_err,
  // CSR responder ports
  output logic [CSR_ADDR_W-1:0] wr_addr,
  output logic [CSR_DATA_W-1:0] wr_data,
  output logic                  wen,
  output logic [CSR_ADDR_W-1:0] rd_addr,
  output logic                  ren,
  input  logic [CSR_DATA_W-1:0] rd_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  // Attempt counter holds 0..POLL_MAX-1. It is sized to hold POLL_MAX so the
  // last-attempt compare never needs a wider operand.
  localparam int ATT_W = $clog2(POLL_MAX + 1);
  localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(POLL_MAX - 1);

  // The gap counter is kept at least 1 bit wide so POLL_GAP=0 still
  // elaborates. In that case the GAP state is simply never entered.
  localparam int GAP_W = $clog2(POLL_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  logic [2:0]            state_q,    state_d;
  logic [1:0]            op_q,       op_d;
  logic [CSR_ADDR_W-1:0] addr_q,     addr_d;
  logic [CSR_DATA_W-1:0] data_q,     data_d;
  logic [CSR_DATA_W-1:0] mask_q,     mask_d;
  logic [CSR_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q,  rsp_err_d;
  logic [ATT_W-1:0]      attempts_q, attempts_d;
  logic [GAP_W-1:0]      gap_q,      gap_d;

  logic poll_match;

  // Poll compare: only the bits selected by the latched mask take part.
  always_comb begin
    poll_match = ((rd_data & mask_q) == (data_q & mask_q));
  end

  // Next-state and datapath decode for the command sequencer.
  // NOTE: every always_comb output gets a default first, so no path can hold
  // an old value and infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    attempts_d = attempts_q;
    gap_d      = gap_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          addr_d     = req_addr;
          data_d     = req_data;
          mask_d     = req_mask;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (req_op)
            OP_WRITE: state_d = S_WRITE;
            OP_READ, OP_POLL: begin
              state_d    = S_READ;
              attempts_d = '0;
            end
            default: begin
              // Reserved op: report an error without touching the CSR bus.
              state_d   = S_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end

      S_WRITE: state_d = S_RESP;

      S_READ: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        // The last value read is always reported, including on poll timeout.
        rsp_data_d = rd_data;
        if (op_q != OP_POLL || poll_match) begin
          state_d = S_RESP;
        end else if (attempts_q == ATT_LAST) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else begin
          attempts_d = attempts_q + ATT_W'(1);
          gap_d      = '0;
          state_d    = (POLL_GAP > 0) ? S_GAP : S_READ;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_READ;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything asynchronously.
  // NOTE: sequential state uses non-blocking assignment only, so every flop
  // samples the pre-edge values no matter what order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_WRITE;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      attempts_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      attempts_q <= attempts_d;
      gap_q      <= gap_d;
    end
  end

  // Outputs are decoded straight from the registered state. The strobes are
  // therefore mutually exclusive and drop as soon as reset is asserted.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    wen       = (state_q == S_WRITE);
    ren       = (state_q == S_READ);
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
    wr_addr   = addr_q;
    rd_addr   = addr_q;
    wr_data   = data_q;
  end

endmodule

// File: tb/tb_uart_csr_master.sv
// Self-checking bench for uart_csr_master. It runs with POLL_MAX=3 and
// POLL_GAP=4, so one build covers poll success, poll timeout and the
// 6-cycle retry spacing.
module tb_uart_csr_master;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int PMAX = 3;
  localparam int PGAP = 4;
  localparam int SPACING = 2 + PGAP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [DW-1:0] req_mask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wen;
  logic [AW-1:0] rd_addr;
  logic          ren;
  logic [DW-1:0] rd_data = '0;

  int checks = 0;
  int failures = 0;

  uart_csr_master #(
    .CSR_ADDR_W(AW), .CSR_DATA_W(DW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .wr_addr(wr_addr), .wr_data(wr_data), .wen(wen),
    .rd_addr(rd_addr), .ren(ren), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Responder model: registered read data, valid the cycle after ren. It
  // returns rd_vals[0], [1], [2], then repeats [2]. Each accepted command
  // restarts the sequence.
  logic [DW-1:0] rd_vals [3];
  int rd_idx = 0;
  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      rd_idx <= 0;
    end else if (ren) begin
      rd_data <= rd_vals[rd_idx];
      if (rd_idx < 2) rd_idx <= rd_idx + 1;
    end
  end

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [DW-1:0] rd0, rd1, rd2;
    int            exp_cyc;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_wen;
    int            exp_ren;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Issues one command (the response is consumed immediately) and checks
  // latency, strobe counts and spacing, and the response contents.
  task automatic run_vec(input vec_t v);
    int wen_n, ren_n, wen_cyc, first_ren, last_ren, bad_gap, rcyc;
    logic got;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rdat;
    logic rerr;
    wen_n = 0; ren_n = 0; wen_cyc = 0; first_ren = 0; last_ren = 0;
    bad_gap = 0; rcyc = 0; got = 1'b0;
    wa = '0; ra = '0; wd = '0; rdat = '0; rerr = 1'b0;
    rd_vals[0] = v.rd0; rd_vals[1] = v.rd1; rd_vals[2] = v.rd2;

    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
    req_data = v.data; req_mask = v.mask; rsp_ready = 1'b1;
    check({v.name, ".req_ready"}, DW'(req_ready), DW'(1));
    @(posedge clk);
    #1;
    // Scramble the request fields to show the command was latched.
    req_valid = 1'b0; req_op = 2'b11; req_addr = '1; req_data = '1; req_mask = '1;

    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (wen) begin
        wen_n++; wen_cyc = c; wa = wr_addr; wd = wr_data;
      end
      if (ren) begin
        if (ren_n > 0 && (c - last_ren) != SPACING) bad_gap++;
        if (ren_n == 0) first_ren = c;
        last_ren = c; ra = rd_addr; ren_n++;
      end
      if (rsp_valid) begin
        got = 1'b1; rcyc = c; rdat = rsp_data; rerr = rsp_err;
      end
    end

    check({v.name, ".got_rsp"},  DW'(got),     DW'(1));
    check({v.name, ".rsp_cyc"},  DW'(rcyc),    DW'(v.exp_cyc));
    check({v.name, ".rsp_data"}, rdat,         v.exp_data);
    check({v.name, ".rsp_err"},  DW'(rerr),    DW'(v.exp_err));
    check({v.name, ".wen_cnt"},  DW'(wen_n),   DW'(v.exp_wen));
    check({v.name, ".ren_cnt"},  DW'(ren_n),   DW'(v.exp_ren));
    if (v.exp_wen > 0) begin
      check({v.name, ".wen_cyc"}, DW'(wen_cyc), DW'(1));
      check({v.name, ".wr_addr"}, DW'(wa),      DW'(v.addr));
      check({v.name, ".wr_data"}, wd,           v.data);
    end
    if (v.exp_ren > 0) begin
      check({v.name, ".ren_cyc"},  DW'(first_ren), DW'(1));
      check({v.name, ".ren_gap"},  DW'(bad_gap),   DW'(0));
      check({v.name, ".rd_addr"},  DW'(ra),        DW'(v.addr));
    end

    @(posedge clk);  // response consumed here (rsp_ready held high)
    @(negedge clk);
    check({v.name, ".idle_after"}, DW'({rsp_valid, req_ready}), DW'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //            name        op     addr  data          mask          rd0           rd1           rd2           cyc data          err wen ren
    vecs[0] = '{"write",     2'b00, 4'h1, 32'h0000_0008, 32'h0,        32'h0,        32'h0,        32'h0,        2,  32'h0,        0, 1, 0};
    vecs[1] = '{"read",      2'b01, 4'h0, 32'h0,         32'h0,        32'hDEAD_BEEF,32'h0,        32'h0,        3,  32'hDEAD_BEEF,0, 0, 1};
    vecs[2] = '{"poll_ok3",  2'b10, 4'h5, 32'h1,         32'h1,        32'h0,        32'h0,        32'h1,        15, 32'h1,        0, 0, 3};
    vecs[3] = '{"poll_tmo",  2'b10, 4'h5, 32'h1,         32'h1,        32'h0,        32'h0,        32'h0,        15, 32'h0,        1, 0, 3};
    vecs[4] = '{"poll_m0",   2'b10, 4'h3, 32'hFFFF_FFFF, 32'h0,        32'h1234,     32'h0,        32'h0,        3,  32'h1234,     0, 0, 1};
    vecs[5] = '{"reserved",  2'b11, 4'h2, 32'h55,        32'h0,        32'h0,        32'h0,        32'h0,        1,  32'h0,        1, 0, 0};
    vecs[6] = '{"poll_fld",  2'b10, 4'h7, 32'h0000_1200, 32'h0000_FF00,32'h0000_12AB,32'h0,        32'h0,        3,  32'h0000_12AB,0, 0, 1};
    vecs[7] = '{"poll_ok2",  2'b10, 4'hA, 32'hFFFF_FFFF, 32'h8000_0000,32'h7FFF_FFFF,32'h8000_0000,32'h0,        9,  32'h8000_0000,0, 0, 2};

    rd_vals[0] = '0; rd_vals[1] = '0; rd_vals[2] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
    req_data = '0; req_mask = '0; rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst.req_ready", DW'(req_ready), DW'(1));
    check("rst.strobes",   DW'({wen, ren, rsp_valid, rsp_err}), DW'(0));
    check("rst.rsp_data",  rsp_data, DW'(0));
    check("rst.csr_addr",  DW'({wr_addr, rd_addr}), DW'(0));
    check("rst.wr_data",   wr_data, DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure on a reserved-op response: it must stay stable, and
    // the next command is only accepted one cycle after the handshake.
    begin
      logic got;
      got = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b1; req_op = 2'b11; req_addr = 4'h9;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      check("bp.got_rsp", DW'(got), DW'(1));
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("bp.hold_ctrl", DW'({rsp_valid, rsp_err, req_ready, wen, ren}), DW'(5'b11000));
        check("bp.hold_data", rsp_data, DW'(0));
      end
      rsp_ready = 1'b1;
      #1;
      check("bp.no_turnaround", DW'(req_ready), DW'(0));
      @(negedge clk);
      check("bp.released", DW'({rsp_valid, req_ready}), DW'(2'b01));
    end

    // Reset asserted mid-poll, while the FSM is in GAP.
    begin
      @(negedge clk);
      rd_vals[0] = '0; rd_vals[1] = '0; rd_vals[2] = '0;
      req_valid = 1'b1; req_op = 2'b10; req_addr = 4'h4;
      req_data = 32'h1; req_mask = 32'h1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (4) @(negedge clk);  // cycle 4 is inside GAP
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst.req_ready", DW'(req_ready), DW'(1));
      check("mid_rst.strobes",   DW'({wen, ren, rsp_valid}), DW'(0));
      check("mid_rst.rd_addr",   DW'(rd_addr), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst.ready_after", DW'(req_ready), DW'(1));
      run_vec(vecs[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
